// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller.
//   - bus register offsets (2-bit addr)
//   - STATUS / CTRL bit positions
//   - serializer state encoding
package uart_tx_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_TX_DONE   = 3;
    localparam int ST_OVERFLOW  = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_TX_EN   = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Synchronous FIFO used as the UART transmit queue.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (accepted when not full, or when
//                full while a pop happens in the same cycle)
//   pop, dout  : read request; dout is valid while not empty
//   full, empty, count : occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot at the same edge, so a push while full is taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: register file, transmit FIFO and 8N1
// serializer.
//   clk, reset          : clock, synchronous active-high reset
//   we, re, addr, wdata : peripheral bus access (re has no side effects)
//   rdata               : combinational read data
//   uart_txd            : serial line, idles high, registered
//   tx_busy             : a frame is on the line
//   irq                 : CTRL.irq_en & STATUS.tx_done
//
// state | meaning
// IDLE  | line high, waiting for tx_en and a queued byte
// START | start bit (low) for DIV cycles
// DATA  | 8 data bits LSB first, DIV cycles each
// STOP  | stop bit (high) for DIV cycles; may chain straight into START
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        irq
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_ctrl: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_ctrl: FIFO_DEPTH must be a power of 2, at least 2");
    end

    tx_state_t         state;
    logic [7:0]        shift;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic              tx_done;
    logic              overflow;
    logic              irq_en;
    logic              tx_en;

    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNTW-1:0]   fifo_count;
    logic              bit_end;
    logic              unused_bus_bits;

    assign unused_bus_bits = &{1'b0, re, wdata[31:8]};

    assign fifo_push = we && (addr == ADDR_TXDATA);
    assign bit_end   = (baud_cnt == CNT_MAX);
    // tx_en here is the registered value, so a CTRL write landing on the
    // same edge as a stop-bit end does not affect that pop decision.
    assign fifo_pop  = tx_en && !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && bit_end));

    assign tx_busy = (state != IDLE);
    assign irq     = irq_en && tx_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_STATUS: begin
                rdata[ST_EMPTY]             = fifo_empty;
                rdata[ST_FULL]              = fifo_full;
                rdata[ST_BUSY]              = tx_busy;
                rdata[ST_TX_DONE]           = tx_done;
                rdata[ST_OVERFLOW]          = overflow;
                rdata[ST_COUNT_LSB +: 4]    = 4'(fifo_count);
            end
            ADDR_CTRL: begin
                rdata[CTRL_IRQ_EN] = irq_en;
                rdata[CTRL_TX_EN]  = tx_en;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            tx_en    <= 1'b1;
        end else begin
            if (we && (addr == ADDR_CTRL)) begin
                irq_en <= wdata[CTRL_IRQ_EN];
                tx_en  <= wdata[CTRL_TX_EN];
            end
            // W1C clears come first so a same-cycle set below wins.
            if (we && (addr == ADDR_STATUS) && wdata[ST_TX_DONE]) begin
                tx_done <= 1'b0;
            end
            if (we && (addr == ADDR_STATUS) && wdata[ST_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        shift    <= fifo_dout;
                        bit_idx  <= '0;
                        uart_txd <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            uart_txd <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        if (fifo_pop) begin
                            shift    <= fifo_dout;
                            bit_idx  <= '0;
                            uart_txd <= 1'b0;
                            state    <= START;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int BITC  = 16;
    localparam int FRAME = 10 * BITC;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_txd;
    logic        tx_busy;
    logic        irq;

    uart_tx_ctrl #(
        .CLK_HZ     (160),
        .BAUD       (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } sb_t;

    sb_t  sb[$];
    int   pend[$];
    int   busy_until = 0;
    bit   model_ovf = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference transmitter: each accepted byte starts at the later of the
    // cycle after its write and the end of the previous frame. A write is
    // dropped when DEPTH earlier bytes are still waiting past that edge.
    task automatic model_write(input logic [7:0] b, input int n);
        int occ = 0;
        int st;
        foreach (pend[i]) if (pend[i] > n) occ++;
        if (occ < DEPTH) begin
            st = (n + 1 > busy_until) ? n + 1 : busy_until;
            busy_until = st + FRAME;
            pend.push_back(st);
            sb.push_back('{b, st});
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    logic mon_bits [FRAME];
    bit   mon_active = 1'b0;
    logic prev_txd = 1'b1;
    int   mon_n = 0;
    int   mon_start = 0;

    task automatic finish_frame();
        logic [7:0] got;
        sb_t        e;
        int         bad;
        logic       lvl;
        frames_seen++;
        for (int k = 0; k < 8; k++) got[k] = mon_bits[BITC * (k + 1) + BITC / 2];
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got=0x%0h exp=none (cycle %0d)", got, cyc);
            return;
        end
        e = sb.pop_front();
        check("frame_byte", 32'(got), 32'(e.data));
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i < BITC) lvl = 1'b0;
            else if (i >= 9 * BITC) lvl = 1'b1;
            else lvl = e.data[i / BITC - 1];
            if (mon_bits[i] !== lvl) bad++;
        end
        check("frame_shape_bad_samples", 32'(bad), 32'd0);
        if (e.start >= 0) check("frame_start_edge", 32'(mon_start), 32'(e.start));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                prev_txd   = 1'b1;
            end else begin
                if (!mon_active && prev_txd === 1'b1 && uart_txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_n      = 0;
                    mon_start  = cyc;
                end
                if (mon_active) begin
                    mon_bits[mon_n] = uart_txd;
                    mon_n++;
                    if (mon_n == FRAME) begin
                        mon_active = 1'b0;
                        finish_frame();
                    end
                end
                prev_txd = uart_txd;
            end
        end
    end

    // ---------------- bus helpers ----------------
    // All helpers are entered shortly after a rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int n);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        n = cyc;
        we = 1'b0;
        wdata = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        re = 1'b1;
        #1;
        d = rdata;
        re = 1'b0;
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i = 0;
        while (frames_seen < target && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("frames_done", 32'(frames_seen), 32'(target));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int n, n0, m, f0, gap;

        step(3);
        reset = 1'b0;

        // ---- reset values and reserved address ----
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        read_reg(2'd1, rd); check("rst_status", rd, 32'h1);
        read_reg(2'd2, rd); check("rst_ctrl", rd, 32'h2);
        read_reg(2'd0, rd); check("txdata_read", rd, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFF, n);
        read_reg(2'd3, rd); check("addr3_read", rd, 32'h0);
        read_reg(2'd2, rd); check("addr3_ctrl_untouched", rd, 32'h2);
        read_reg(2'd1, rd); check("addr3_no_push", rd, 32'h1);

        // ---- 1: single 0x55 frame, latency and completion ----
        bus_write(2'd0, 32'h55, n);
        model_write(8'h55, n);
        check("t1_txd_before_pop", 32'(uart_txd), 32'd1);
        step(1);
        check("t1_txd_start", 32'(uart_txd), 32'd0);
        check("t1_busy", 32'(tx_busy), 32'd1);
        wait_until(n + FRAME);
        check("t1_busy_last_cycle", 32'(tx_busy), 32'd1);
        wait_frames(1, FRAME + 20);
        wait_until(n + FRAME + 1);
        check("t1_busy_after", 32'(tx_busy), 32'd0);
        read_reg(2'd1, rd); check("t1_status_done", rd, 32'h9);

        // ---- 2: back-to-back 0xA3, 0x0F ----
        bus_write(2'd1, 32'h8, n);
        bus_write(2'd0, 32'hA3, n);
        model_write(8'hA3, n);
        bus_write(2'd0, 32'h0F, n);
        model_write(8'h0F, n);
        read_reg(2'd1, rd); check("t2_status_count1", rd, 32'h104);
        wait_frames(3, 2 * FRAME + 20);

        // ---- 3: overflow with tx_en=0 ----
        bus_write(2'd1, 32'h18, n);
        bus_write(2'd2, 32'h0, n);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            bus_write(2'd0, {24'd0, b}, n);
            if (i < DEPTH) sb.push_back('{b, -1});
        end
        read_reg(2'd1, rd); check("t3_status_full_ovf", rd, 32'h812);
        f0 = frames_seen;
        step(50);
        check("t3_no_tx_while_disabled", 32'(frames_seen - f0), 32'd0);
        check("t3_busy_disabled", 32'(tx_busy), 32'd0);
        bus_write(2'd2, 32'h2, n);
        wait_frames(f0 + DEPTH, DEPTH * FRAME + 50);
        read_reg(2'd1, rd); check("t3_status_drained", rd, 32'h19);
        bus_write(2'd1, 32'h18, n);
        read_reg(2'd1, rd); check("t3_status_w1c", rd, 32'h1);

        // ---- 4: irq and W1C collision ----
        bus_write(2'd2, 32'h3, n);
        b = 8'($urandom);
        bus_write(2'd0, {24'd0, b}, n);
        model_write(b, n);
        n0 = n;
        wait_until(n0 + FRAME);
        check("t4_irq_before_end", 32'(irq), 32'd0);
        bus_write(2'd1, 32'h8, n);
        check("t4_collision_edge", 32'(n), 32'(n0 + FRAME + 1));
        check("t4_irq_set_wins", 32'(irq), 32'd1);
        read_reg(2'd1, rd); check("t4_tx_done_kept", rd & 32'h8, 32'h8);
        bus_write(2'd1, 32'h8, n);
        check("t4_irq_cleared", 32'(irq), 32'd0);
        bus_write(2'd2, 32'h2, n);
        wait_frames(f0 + DEPTH + 1, 20);

        // ---- 5: reset during DATA bit 3 with 3 bytes queued ----
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            bus_write(2'd0, {24'd0, b}, n);
            if (i == 0) n0 = n;
            model_write(b, n);
        end
        wait_until(n0 + 70);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        sb.delete();
        pend.delete();
        busy_until = 0;
        check("t5_txd_high", 32'(uart_txd), 32'd1);
        check("t5_busy", 32'(tx_busy), 32'd0);
        read_reg(2'd1, rd); check("t5_status_empty", rd, 32'h1);
        read_reg(2'd2, rd); check("t5_ctrl_reset", rd, 32'h2);
        f0 = frames_seen;
        step(2 * FRAME);
        check("t5_no_frames", 32'(frames_seen - f0), 32'd0);
        check("t5_txd_idle", 32'(uart_txd), 32'd1);

        // ---- 6: clear tx_en during START of first of two bytes ----
        b = 8'($urandom);
        bus_write(2'd0, {24'd0, b}, n);
        n0 = n;
        sb.push_back('{b, n0 + 1});
        b = 8'($urandom);
        bus_write(2'd0, {24'd0, b}, n);
        sb.push_back('{b, -1});
        bus_write(2'd2, 32'h0, n);
        wait_frames(f0 + 1, FRAME + 20);
        wait_until(n0 + FRAME + 4);
        check("t6_idle_after_byte1", 32'(tx_busy), 32'd0);
        read_reg(2'd1, rd); check("t6_status_one_left", rd, 32'h108);
        step(40);
        check("t6_still_idle", 32'(tx_busy), 32'd0);
        bus_write(2'd2, 32'h2, m);
        check("t6_txd_before_pop", 32'(uart_txd), 32'd1);
        step(1);
        check("t6_txd_start", 32'(uart_txd), 32'd0);
        wait_frames(f0 + 2, FRAME + 20);
        step(2);

        // ---- random phase against the timing model ----
        bus_write(2'd1, 32'h18, n);
        model_ovf = 1'b0;
        pend.delete();
        busy_until = 0;
        f0 = frames_seen;
        for (int i = 0; i < 30; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 300) : $urandom_range(0, 2);
            step(gap);
            b = 8'($urandom);
            bus_write(2'd0, {24'd0, b}, n);
            model_write(b, n);
        end
        wait_frames(f0 + pend.size(), 32 * FRAME);
        step(2);
        read_reg(2'd1, rd);
        check("rand_status_end", rd, 32'h9 | (32'(model_ovf) << 4));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
